spi_cfg_regs: RTL and testbench
===============================

Name: spi_cfg_regs

Overview:
Addressable SPI configuration register file; the parametrised successor of the single-word SPI config receiver.
- Holds NUM_REGS registers of DATA_W bits each.
- Supports write and read-back (MISO) frames, a selectable SCK idle polarity, and a frame-error pulse and counter.
- Sits between the external SPI pins and the NCO, gain and filter control inputs of the radio datapath.

Parameters:
NUM_REGS, 4, number of registers (1..128).
DATA_W, 24, register width in bits (8..32).
SYNC_STAGES, 2, synchroniser flops on CS, SCK and MOSI (>=2).
CPOL, 0, SCK idle level; data is always sampled on the leading edge of SCK and driven on the trailing edge.
RESET_VALS, {NUM_REGS*DATA_W{1'b0}} except reg0 = 24'h502735, flattened per-register reset values; reg i occupies bits [i*DATA_W +: DATA_W].

Ports:
CLK  in  1  system clock
RSTb  in  1  asynchronous active-low reset
MOSI  in  1  SPI data in (asynchronous)
SCK  in  1  SPI clock (asynchronous); must satisfy f_SCK <= f_CLK/8
CS  in  1  SPI chip select, active low (asynchronous)
MISO  out  1  SPI read data
miso_oe  out  1  MISO output enable; high while a frame is in progress
regs  out  NUM_REGS*DATA_W  all register contents, flattened
wr_strobe  out  NUM_REGS  one-cycle pulse on the register written
frame_err  out  1  one-cycle pulse when a frame is rejected
err_count  out  8  saturating count of rejected frames

Behaviour:
- Reset (asynchronous, RSTb=0):
  - regs=RESET_VALS; MISO=0; miso_oe=0; wr_strobe=0; frame_err=0; err_count=0.
  - State IDLE. Synchronisers are cleared to the idle values: CS=1, SCK=CPOL, MOSI=0.
  - Reset asserted mid-frame aborts the frame; nothing is committed.
- Inputs pass through SYNC_STAGES flops. Edge detection compares the last synchronised stage with one further delay flop.
- Leading edge = rising when CPOL=0, falling when CPOL=1. Trailing edge is the opposite.
- Frame format, MSB first:
  - Bit 7 of the header = RW (1 = write, 0 = read); bits 6:0 = address.
  - Then DATA_W data bits.
- FSM states:
  - IDLE: on a synchronised CS falling edge -> ADDR. Clear the shift register and bit counter; miso_oe=1.
  - ADDR: shift MOSI on each leading edge. After the 8th bit -> DATA.
    - On a read, load the output shift register with regs[addr], or 0 if addr >= NUM_REGS.
  - DATA: write -> shift MOSI on leading edges, counting bits. Read -> on each trailing edge, MISO <= next bit, MSB first.
    - The first data bit is driven on the trailing edge after the 8th header bit.
  - COMMIT: entered on a synchronised CS rising edge from ADDR or DATA. miso_oe=0.
    - Write frame with exactly DATA_W data bits and addr < NUM_REGS: regs[addr] <= received word, and wr_strobe[addr]=1 in the same cycle the new value appears.
    - Read frame with at least 8 bits: no register change, no error.
    - Otherwise (short or long frame, or out-of-range write): frame_err=1 and err_count += 1, saturating at 255.
    - COMMIT -> IDLE after one cycle.
- CS rising edge detected in ADDR with fewer than 8 bits: counts as a rejected frame (via COMMIT).
- Extra SCK edges beyond 8+DATA_W bits:
  - Write: bit counter saturates and the frame is flagged long (rejected at commit).
  - Read: MISO shifts out zeros.
- Latency: the CS pin rising edge is sampled at CLK edge n. regs and wr_strobe update at edge n+SYNC_STAGES+2.
- Minimum CS high time: SYNC_STAGES+3 CLK cycles. A CS falling edge seen in COMMIT is ignored.
- MISO is 0 whenever miso_oe=0.
- Width rules: address compares use 7 bits; received word is DATA_W bits; no truncation elsewhere.

Decomposition:
- Shared package spi_pkg:
  - FSM state encoding (IDLE, ADDR, DATA, COMMIT).
  - HDR_BITS=8, RW_BIT=7, ADDR_BITS=7, ERR_CNT_W=8.
- One sub-module spi_sync: SYNC_STAGES-deep synchroniser plus edge detector.
  - Parameters: reset value and stage count.
  - Outputs: level, rise, fall.
  - Instantiated three times.

Test Plan:
1. Reset: assert RSTb=0 mid-run -> regs[23:0]=0x502735, other regs 0, err_count=0, MISO=0, miso_oe=0 immediately (asynchronous).
2. Write, CPOL=0, SCK=CLK/8: header 0x81, data 0x5A1234 -> regs[1]=0x5A1234; wr_strobe=4'b0010 for exactly one cycle, SYNC_STAGES+2 cycles after the CS pin rises; other regs unchanged.
3. Read-back: header 0x01 plus 24 clocks -> MISO bitstream 0x5A1234, MSB first, each bit stable across the leading edge; miso_oe high only while CS is low.
4. Short write: header 0x80 plus 10 data bits, then CS high -> regs[0] unchanged, frame_err pulse, err_count=1. Repeat 300 times -> err_count=255.
5. Out-of-range: write to addr 0x05 (NUM_REGS=4) -> frame_err pulse, no wr_strobe. Read from 0x05 -> MISO all zeros, no error.
6. CPOL=1 build: same write as scenario 2 with SCK idling high -> regs[1]=0x5A1234. Async reset mid-DATA -> register keeps its reset value, and the next frame is received correctly.

Source files
------------

// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared FSM encoding and frame constants for the SPI config register file
package spi_pkg;
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_COMMIT
    } spi_state_e;

    localparam int HDR_BITS  = 8;
    localparam int RW_BIT    = 7;
    localparam int ADDR_BITS = 7;
    localparam int ERR_CNT_W = 8;
endpackage

// File: rtl/spi_sync.sv
// rtl/spi_sync.sv - multi-flop synchroniser with registered rise/fall detection
module spi_sync #(
    parameter logic RESET_VAL = 1'b0,
    parameter int   STAGES    = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);
    logic [STAGES-1:0] sync_q, sync_d;
    logic              dly_q, dly_d;
    logic              rise_q, rise_d;
    logic              fall_q, fall_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], din};
        dly_d  = sync_q[STAGES-1];
        rise_d = sync_q[STAGES-1] & ~dly_q;
        fall_d = ~sync_q[STAGES-1] & dly_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {STAGES{RESET_VAL}};
            dly_q  <= RESET_VAL;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            dly_q  <= dly_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    // level is taken from the delay flop so it lines up with the registered edge flags
    assign level = dly_q;
    assign rise  = rise_q;
    assign fall  = fall_q;
endmodule

// File: rtl/spi_cfg_regs.sv
// rtl/spi_cfg_regs.sv - addressable SPI configuration register file with read-back and frame error counting
module spi_cfg_regs
    import spi_pkg::*;
#(
    parameter int   NUM_REGS    = 4,
    parameter int   DATA_W      = 24,
    parameter int   SYNC_STAGES = 2,
    parameter logic CPOL        = 1'b0,
    parameter logic [NUM_REGS*DATA_W-1:0] RESET_VALS = (NUM_REGS*DATA_W)'(24'h502735)
) (
    input  logic                         CLK,
    input  logic                         RSTb,
    input  logic                         MOSI,
    input  logic                         SCK,
    input  logic                         CS,
    output logic                         MISO,
    output logic                         miso_oe,
    output logic [NUM_REGS*DATA_W-1:0]   regs,
    output logic [NUM_REGS-1:0]          wr_strobe,
    output logic                         frame_err,
    output logic [ERR_CNT_W-1:0]         err_count
);
    localparam int CNT_MAX = HDR_BITS + DATA_W + 1;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    logic cs_lvl, cs_rise, cs_fall;
    logic sck_lvl, sck_rise, sck_fall;
    logic mosi_lvl, mosi_rise, mosi_fall;
    logic unused_mosi_edges;

    spi_sync #(.RESET_VAL(1'b1), .STAGES(SYNC_STAGES)) u_sync_cs (
        .clk(CLK), .rst_n(RSTb), .din(CS), .level(cs_lvl), .rise(cs_rise), .fall(cs_fall)
    );
    spi_sync #(.RESET_VAL(CPOL), .STAGES(SYNC_STAGES)) u_sync_sck (
        .clk(CLK), .rst_n(RSTb), .din(SCK), .level(sck_lvl), .rise(sck_rise), .fall(sck_fall)
    );
    spi_sync #(.RESET_VAL(1'b0), .STAGES(SYNC_STAGES)) u_sync_mosi (
        .clk(CLK), .rst_n(RSTb), .din(MOSI), .level(mosi_lvl), .rise(mosi_rise), .fall(mosi_fall)
    );
    assign unused_mosi_edges = mosi_rise | mosi_fall;

    spi_state_e                  state_q, state_d;
    logic [HDR_BITS-1:0]         hdr_q, hdr_d;
    logic [DATA_W-1:0]           shift_q, shift_d;
    logic [DATA_W-1:0]           out_q, out_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic                        miso_q, miso_d;
    logic                        oe_q, oe_d;
    logic [NUM_REGS*DATA_W-1:0]  regs_q, regs_d;
    logic [NUM_REGS-1:0]         wr_strobe_q, wr_strobe_d;
    logic                        frame_err_q, frame_err_d;
    logic [ERR_CNT_W-1:0]        err_count_q, err_count_d;

    logic                        cs_start, cs_stop, lead, trail;
    logic [HDR_BITS-1:0]         hdr_shift;
    logic [CNT_W-1:0]            cnt_inc;
    logic [DATA_W-1:0]           rd_word;
    logic                        commit_err;

    // an SCK edge is leading when SCK has just left its idle level
    assign lead     = (sck_rise | sck_fall) & (sck_lvl != CPOL);
    assign trail    = (sck_rise | sck_fall) & (sck_lvl == CPOL);
    assign cs_start = (cs_rise | cs_fall) & ~cs_lvl;
    assign cs_stop  = (cs_rise | cs_fall) & cs_lvl;

    always_comb begin
        hdr_shift = {hdr_q[HDR_BITS-2:0], mosi_lvl};
        cnt_inc   = (cnt_q == CNT_W'(CNT_MAX)) ? cnt_q : cnt_q + CNT_W'(1);
        rd_word   = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (hdr_shift[ADDR_BITS-1:0] == ADDR_BITS'(i)) begin
                rd_word = regs_q[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        hdr_d       = hdr_q;
        shift_d     = shift_q;
        out_d       = out_q;
        cnt_d       = cnt_q;
        miso_d      = miso_q;
        oe_d        = oe_q;
        regs_d      = regs_q;
        wr_strobe_d = '0;
        frame_err_d = 1'b0;
        err_count_d = err_count_q;
        commit_err  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cs_start) begin
                    state_d = ST_ADDR;
                    hdr_d   = '0;
                    shift_d = '0;
                    out_d   = '0;
                    cnt_d   = '0;
                    miso_d  = 1'b0;
                    oe_d    = 1'b1;
                end
            end
            ST_ADDR: begin
                if (cs_stop) begin
                    state_d = ST_COMMIT;
                    oe_d    = 1'b0;
                    miso_d  = 1'b0;
                end else if (lead) begin
                    hdr_d = hdr_shift;
                    cnt_d = cnt_inc;
                    if (cnt_q == CNT_W'(HDR_BITS - 1)) begin
                        state_d = ST_DATA;
                        if (!hdr_shift[RW_BIT]) begin
                            out_d = rd_word;
                        end
                    end
                end
            end
            ST_DATA: begin
                if (cs_stop) begin
                    state_d = ST_COMMIT;
                    oe_d    = 1'b0;
                    miso_d  = 1'b0;
                end else begin
                    if (lead) begin
                        cnt_d = cnt_inc;
                        if (hdr_q[RW_BIT]) begin
                            shift_d = {shift_q[DATA_W-2:0], mosi_lvl};
                        end
                    end
                    // reads drain zeros once the word has been shifted out
                    if (trail && !hdr_q[RW_BIT]) begin
                        miso_d = out_q[DATA_W-1];
                        out_d  = {out_q[DATA_W-2:0], 1'b0};
                    end
                end
            end
            ST_COMMIT: begin
                state_d = ST_IDLE;
                if (cnt_q < CNT_W'(HDR_BITS)) begin
                    commit_err = 1'b1;
                end else if (hdr_q[RW_BIT]) begin
                    commit_err = 1'b1;
                    if (cnt_q == CNT_W'(HDR_BITS + DATA_W)) begin
                        for (int i = 0; i < NUM_REGS; i++) begin
                            if (hdr_q[ADDR_BITS-1:0] == ADDR_BITS'(i)) begin
                                regs_d[i*DATA_W +: DATA_W] = shift_q;
                                wr_strobe_d[i]             = 1'b1;
                                commit_err                 = 1'b0;
                            end
                        end
                    end
                end
                if (commit_err) begin
                    frame_err_d = 1'b1;
                    if (err_count_q != '1) begin
                        err_count_d = err_count_q + ERR_CNT_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            state_q     <= ST_IDLE;
            hdr_q       <= '0;
            shift_q     <= '0;
            out_q       <= '0;
            cnt_q       <= '0;
            miso_q      <= 1'b0;
            oe_q        <= 1'b0;
            regs_q      <= RESET_VALS;
            wr_strobe_q <= '0;
            frame_err_q <= 1'b0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            hdr_q       <= hdr_d;
            shift_q     <= shift_d;
            out_q       <= out_d;
            cnt_q       <= cnt_d;
            miso_q      <= miso_d;
            oe_q        <= oe_d;
            regs_q      <= regs_d;
            wr_strobe_q <= wr_strobe_d;
            frame_err_q <= frame_err_d;
            err_count_q <= err_count_d;
        end
    end

    assign MISO      = miso_q & oe_q;
    assign miso_oe   = oe_q;
    assign regs      = regs_q;
    assign wr_strobe = wr_strobe_q;
    assign frame_err = frame_err_q;
    assign err_count = err_count_q;
endmodule

// File: tb/tb_spi_cfg_regs.sv
// tb/tb_spi_cfg_regs.sv - self-checking bench driving CPOL=0 and CPOL=1 instances from one SPI master
module tb_spi_cfg_regs;
    localparam int NUM_REGS = 4;
    localparam int DATA_W   = 24;
    localparam int SS       = 2;
    localparam int RW       = NUM_REGS * DATA_W;

    logic clk     = 1'b0;
    logic rstb    = 1'b0;
    logic mosi    = 1'b0;
    logic cs      = 1'b1;
    logic sck_act = 1'b0;
    logic sck0, sck1;
    logic miso0, miso1, oe0, oe1, ferr0, ferr1;
    logic [RW-1:0]       regs0, regs1;
    logic [NUM_REGS-1:0] wr0, wr1;
    logic [7:0]          ecnt0, ecnt1;

    assign sck0 = sck_act;
    assign sck1 = ~sck_act;
    always #5 clk = ~clk;

    spi_cfg_regs #(.NUM_REGS(NUM_REGS), .DATA_W(DATA_W), .SYNC_STAGES(SS), .CPOL(1'b0)) dut0 (
        .CLK(clk), .RSTb(rstb), .MOSI(mosi), .SCK(sck0), .CS(cs), .MISO(miso0), .miso_oe(oe0),
        .regs(regs0), .wr_strobe(wr0), .frame_err(ferr0), .err_count(ecnt0)
    );
    spi_cfg_regs #(.NUM_REGS(NUM_REGS), .DATA_W(DATA_W), .SYNC_STAGES(SS), .CPOL(1'b1)) dut1 (
        .CLK(clk), .RSTb(rstb), .MOSI(mosi), .SCK(sck1), .CS(cs), .MISO(miso1), .miso_oe(oe1),
        .regs(regs1), .wr_strobe(wr1), .frame_err(ferr1), .err_count(ecnt1)
    );

    int n_cmp = 0;
    int n_fail = 0;

    logic [DATA_W-1:0] m_regs [NUM_REGS];
    int m_err;

    logic [63:0] rx0, rx1;
    logic [NUM_REGS-1:0] strobe_v0, strobe_v1;
    int strobe_k0, strobe_k1, strobe_n0, strobe_n1, err_n0, err_n1, oe_bad, unstable;

    function automatic void model_reset();
        for (int i = 0; i < NUM_REGS; i++) m_regs[i] = '0;
        m_regs[0] = 24'h502735;
        m_err = 0;
    endfunction

    function automatic logic [RW-1:0] model_flat();
        logic [RW-1:0] f;
        for (int i = 0; i < NUM_REGS; i++) f[i*DATA_W +: DATA_W] = m_regs[i];
        return f;
    endfunction

    function automatic void model_frame(input logic [7:0] hdr, input int nd, input logic [DATA_W-1:0] data,
                                        output logic wr_ok, output logic err, output logic [63:0] exp_rx);
        int a;
        logic [DATA_W-1:0] word;
        a = int'(hdr[6:0]);
        word = (a < NUM_REGS) ? m_regs[a] : '0;
        exp_rx = '0;
        if (!hdr[7]) begin
            for (int j = 0; j < nd; j++) exp_rx = {exp_rx[62:0], (j < DATA_W) ? word[DATA_W-1-j] : 1'b0};
        end
        wr_ok = 1'b0;
        err = 1'b0;
        if (nd < 0) err = 1'b1;
        else if (hdr[7]) begin
            if (nd == DATA_W && a < NUM_REGS) begin
                m_regs[a] = data;
                wr_ok = 1'b1;
            end else err = 1'b1;
        end
        if (err && m_err < 255) m_err++;
    endfunction

    // sends 8+nd bits (nd may be negative for a truncated header), then watches 12 cycles after CS rises
    task automatic send_frame(input logic [7:0] hdr, input int nd, input logic [DATA_W-1:0] data);
        @(negedge clk);
        cs = 1'b0;
        rx0 = '0; rx1 = '0; oe_bad = 0; unstable = 0;
        repeat (6) @(negedge clk);
        for (int i = 0; i < 8 + nd; i++) begin
            logic b;
            if (i < 8) b = hdr[7-i];
            else if (i - 8 < DATA_W) b = data[DATA_W-1-(i-8)];
            else b = 1'($urandom_range(0, 1));
            mosi = b;
            repeat (4) @(negedge clk);
            if (i >= 8) begin
                rx0 = {rx0[62:0], miso0};
                rx1 = {rx1[62:0], miso1};
                if (!oe0 || !oe1) oe_bad++;
            end
            sck_act = 1'b1;
            repeat (2) @(negedge clk);
            if (i >= 8 && (miso0 !== rx0[0] || miso1 !== rx1[0])) unstable++;
            repeat (2) @(negedge clk);
            sck_act = 1'b0;
        end
        repeat (4) @(negedge clk);
        cs = 1'b1;
        mosi = 1'b0;
        strobe_k0 = -1; strobe_k1 = -1; strobe_n0 = 0; strobe_n1 = 0;
        strobe_v0 = '0; strobe_v1 = '0; err_n0 = 0; err_n1 = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (wr0 != '0) begin
                if (strobe_k0 < 0) begin strobe_k0 = k; strobe_v0 = wr0; end
                strobe_n0++;
            end
            if (wr1 != '0) begin
                if (strobe_k1 < 0) begin strobe_k1 = k; strobe_v1 = wr1; end
                strobe_n1++;
            end
            if (ferr0) err_n0++;
            if (ferr1) err_n1++;
            if (k >= 6 && (oe0 || oe1 || miso0 || miso1)) oe_bad++;
        end
    endtask

    task automatic test_reset();
        rstb = 1'b0;
        repeat (3) @(negedge clk);
        model_reset();
        n_cmp++;
        if ({regs0, regs1} !== {model_flat(), model_flat()}) begin
            n_fail++;
            $display("FAIL reset_regs got %h / %h want %h", regs0, regs1, model_flat());
        end
        n_cmp++;
        if ({ecnt0, ecnt1, miso0, miso1, oe0, oe1, wr0, wr1, ferr0, ferr1} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs got ecnt %0d/%0d miso %b%b oe %b%b wr %b/%b ferr %b%b want all zero",
                     ecnt0, ecnt1, miso0, miso1, oe0, oe1, wr0, wr1, ferr0, ferr1);
        end
        rstb = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_write();
        logic wr_ok, err;
        logic [63:0] exp_rx;
        send_frame(8'h81, DATA_W, 24'h5A1234);
        model_frame(8'h81, DATA_W, 24'h5A1234, wr_ok, err, exp_rx);
        n_cmp++;
        if (regs0[DATA_W +: DATA_W] !== 24'h5A1234 || regs1[DATA_W +: DATA_W] !== 24'h5A1234) begin
            n_fail++;
            $display("FAIL write_reg1 got %h / %h want 5a1234", regs0[DATA_W +: DATA_W], regs1[DATA_W +: DATA_W]);
        end
        n_cmp++;
        if ({regs0, regs1} !== {model_flat(), model_flat()}) begin
            n_fail++;
            $display("FAIL write_others got %h / %h want %h", regs0, regs1, model_flat());
        end
        n_cmp++;
        if (strobe_v0 !== 4'b0010 || strobe_v1 !== 4'b0010 || strobe_k0 != SS + 2 || strobe_k1 != SS + 2
            || strobe_n0 != 1 || strobe_n1 != 1) begin
            n_fail++;
            $display("FAIL write_strobe got %b@%0d x%0d / %b@%0d x%0d want 0010@%0d x1",
                     strobe_v0, strobe_k0, strobe_n0, strobe_v1, strobe_k1, strobe_n1, SS + 2);
        end
        n_cmp++;
        if (err_n0 != 0 || err_n1 != 0) begin
            n_fail++;
            $display("FAIL write_no_err got %0d / %0d pulses want 0", err_n0, err_n1);
        end
    endtask

    task automatic test_read();
        logic wr_ok, err;
        logic [63:0] exp_rx;
        send_frame(8'h01, DATA_W, '0);
        model_frame(8'h01, DATA_W, '0, wr_ok, err, exp_rx);
        n_cmp++;
        if (rx0[DATA_W-1:0] !== 24'h5A1234 || rx1[DATA_W-1:0] !== 24'h5A1234) begin
            n_fail++;
            $display("FAIL read_miso got %h / %h want 5a1234", rx0[DATA_W-1:0], rx1[DATA_W-1:0]);
        end
        n_cmp++;
        if (unstable != 0 || oe_bad != 0) begin
            n_fail++;
            $display("FAIL read_timing got unstable %0d oe_bad %0d want 0 0", unstable, oe_bad);
        end
        n_cmp++;
        if (err_n0 != 0 || err_n1 != 0 || ecnt0 !== 8'(m_err) || ecnt1 !== 8'(m_err)) begin
            n_fail++;
            $display("FAIL read_no_err got pulses %0d/%0d count %0d/%0d want 0 %0d", err_n0, err_n1, ecnt0, ecnt1, m_err);
        end
    endtask

    task automatic test_out_of_range();
        logic wr_ok, err;
        logic [63:0] exp_rx;
        send_frame(8'h85, DATA_W, 24'hABCDEF);
        model_frame(8'h85, DATA_W, 24'hABCDEF, wr_ok, err, exp_rx);
        n_cmp++;
        if (err_n0 != 1 || err_n1 != 1 || strobe_k0 != -1 || strobe_k1 != -1) begin
            n_fail++;
            $display("FAIL oor_write got err %0d/%0d strobe@%0d/%0d want err 1 no strobe", err_n0, err_n1, strobe_k0, strobe_k1);
        end
        n_cmp++;
        if ({regs0, regs1} !== {model_flat(), model_flat()} || ecnt0 !== 8'(m_err) || ecnt1 !== 8'(m_err)) begin
            n_fail++;
            $display("FAIL oor_state got cnt %0d/%0d want %0d", ecnt0, ecnt1, m_err);
        end
        send_frame(8'h05, DATA_W, '0);
        model_frame(8'h05, DATA_W, '0, wr_ok, err, exp_rx);
        n_cmp++;
        if (rx0 !== 64'd0 || rx1 !== 64'd0 || err_n0 != 0 || err_n1 != 0) begin
            n_fail++;
            $display("FAIL oor_read got miso %h / %h err %0d/%0d want 0 no err", rx0, rx1, err_n0, err_n1);
        end
    endtask

    task automatic test_short_write();
        logic wr_ok, err;
        logic [63:0] exp_rx;
        send_frame(8'h80, 10, 24'h3FF000);
        model_frame(8'h80, 10, 24'h3FF000, wr_ok, err, exp_rx);
        n_cmp++;
        if ({regs0, regs1} !== {model_flat(), model_flat()} || err_n0 != 1 || err_n1 != 1
            || ecnt0 !== 8'(m_err) || ecnt1 !== 8'(m_err)) begin
            n_fail++;
            $display("FAIL short_write got err %0d/%0d cnt %0d/%0d want 1 %0d", err_n0, err_n1, ecnt0, ecnt1, m_err);
        end
        for (int r = 1; r < 300; r++) begin
            send_frame(8'h80, 10, 24'h3FF000);
            model_frame(8'h80, 10, 24'h3FF000, wr_ok, err, exp_rx);
        end
        n_cmp++;
        if (ecnt0 !== 8'd255 || ecnt1 !== 8'd255) begin
            n_fail++;
            $display("FAIL err_saturate got %0d / %0d want 255", ecnt0, ecnt1);
        end
    endtask

    task automatic test_random();
        for (int f = 0; f < 25; f++) begin
            logic [7:0] hdr;
            logic [DATA_W-1:0] data;
            logic wr_ok, err;
            logic [63:0] exp_rx;
            logic [NUM_REGS-1:0] exp_v;
            int nd;
            hdr  = {1'($urandom_range(0, 1)), 7'($urandom_range(0, 5))};
            data = DATA_W'($urandom);
            case ($urandom_range(0, 3))
                0, 1:    nd = DATA_W;
                2:       nd = int'($urandom_range(0, 30));
                default: nd = -int'($urandom_range(1, 5));
            endcase
            send_frame(hdr, nd, data);
            model_frame(hdr, nd, data, wr_ok, err, exp_rx);
            exp_v = wr_ok ? (NUM_REGS'(1) << hdr[6:0]) : '0;
            n_cmp++;
            if ({regs0, regs1} !== {model_flat(), model_flat()} || ecnt0 !== 8'(m_err) || ecnt1 !== 8'(m_err)) begin
                n_fail++;
                $display("FAIL rand_state f%0d hdr %h nd %0d got %h cnt %0d want %h cnt %0d", f, hdr, nd, regs0, ecnt0, model_flat(), m_err);
            end
            n_cmp++;
            if (err_n0 != int'(err) || err_n1 != int'(err) || strobe_v0 !== exp_v || strobe_v1 !== exp_v
                || (wr_ok && (strobe_k0 != SS + 2 || strobe_k1 != SS + 2 || strobe_n0 != 1 || strobe_n1 != 1))) begin
                n_fail++;
                $display("FAIL rand_pulses f%0d got err %0d/%0d strobe %b@%0d/%b@%0d want err %0d strobe %b@%0d",
                         f, err_n0, err_n1, strobe_v0, strobe_k0, strobe_v1, strobe_k1, err, exp_v, SS + 2);
            end
            n_cmp++;
            if (rx0 !== exp_rx || rx1 !== exp_rx || oe_bad != 0) begin
                n_fail++;
                $display("FAIL rand_miso f%0d got %h / %h oe_bad %0d want %h", f, rx0, rx1, oe_bad, exp_rx);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        logic wr_ok, err;
        logic [63:0] exp_rx;
        logic [7:0] hdr;
        logic [DATA_W-1:0] data;
        hdr = 8'h82;
        @(negedge clk);
        cs = 1'b0;
        repeat (6) @(negedge clk);
        for (int i = 0; i < 18; i++) begin
            mosi = (i < 8) ? hdr[7-i] : 1'b1;
            repeat (4) @(negedge clk);
            sck_act = 1'b1;
            repeat (4) @(negedge clk);
            sck_act = 1'b0;
        end
        repeat (2) @(negedge clk);
        n_cmp++;
        if (oe0 !== 1'b1 || oe1 !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_frame_oe got %b / %b want 1", oe0, oe1);
        end
        #2 rstb = 1'b0;
        #1;
        model_reset();
        n_cmp++;
        if ({regs0, regs1} !== {model_flat(), model_flat()}) begin
            n_fail++;
            $display("FAIL async_reset_regs got %h / %h want %h", regs0, regs1, model_flat());
        end
        n_cmp++;
        if ({ecnt0, ecnt1, miso0, miso1, oe0, oe1, wr0, wr1, ferr0, ferr1} !== '0) begin
            n_fail++;
            $display("FAIL async_reset_outputs got ecnt %0d/%0d oe %b%b miso %b%b want all zero", ecnt0, ecnt1, oe0, oe1, miso0, miso1);
        end
        @(negedge clk);
        cs = 1'b1;
        mosi = 1'b0;
        repeat (3) @(negedge clk);
        rstb = 1'b1;
        repeat (2) @(negedge clk);
        data = DATA_W'($urandom);
        send_frame(hdr, DATA_W, data);
        model_frame(hdr, DATA_W, data, wr_ok, err, exp_rx);
        n_cmp++;
        if ({regs0, regs1} !== {model_flat(), model_flat()} || strobe_v0 !== 4'b0100 || strobe_v1 !== 4'b0100
            || err_n0 != 0 || err_n1 != 0) begin
            n_fail++;
            $display("FAIL post_reset_write got %h strobe %b/%b want %h strobe 0100", regs0, strobe_v0, strobe_v1, model_flat());
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_out_of_range();
        test_short_write();
        test_random();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
